// File: rtl/seq_cmp_pkg.sv
// Shared constants for the sequential magnitude comparator: FSM state
// encoding and one-hot result-flag encoding {gt, lt, eq}.
package seq_cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

  function automatic logic [2:0] res_from_gt(input logic gt);
    return gt ? RES_GT : RES_LT;
  endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Request/result bundle for seq_mag_comparator; the requester is the master.
interface seq_mag_comparator_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic [CW-1:0]    bits_used;

  modport master (
    output start, a, b,
    input  busy, done, a_gt_b, a_lt_b, a_eq_b, bits_used
  );

  modport slave (
    input  start, a, b,
    output busy, done, a_gt_b, a_lt_b, a_eq_b, bits_used
  );
endinterface

// File: rtl/seq_mag_comparator_bit_slice.sv
// Single bit-pair decision: flags a difference and, if so, whether A wins.
module cmp_bit_slice (
  input  logic a_bit_i,
  input  logic b_bit_i,
  input  logic is_msb_i,
  input  logic signed_i,
  output logic differ_o,
  output logic gt_o
);
  // In two's complement the sign bit carries negative weight, so a set bit loses.
  always_comb begin
    differ_o = a_bit_i ^ b_bit_i;
    gt_o     = differ_o & ((is_msb_i & signed_i) ? b_bit_i : a_bit_i);
  end
endmodule

// File: rtl/seq_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with early termination on the
// first differing bit; one bit examined per cycle.
module seq_mag_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  seq_mag_comparator_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    used_q, used_d;
  logic [2:0]       res_q, res_d;
  logic             differ, gt;

  cmp_bit_slice u_slice (
    .a_bit_i  (a_q[idx_q]),
    .b_bit_i  (b_q[idx_q]),
    .is_msb_i (idx_q == IW'(WIDTH - 1)),
    .signed_i (SIGNED),
    .differ_o (differ),
    .gt_o     (gt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    used_d  = used_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = IW'(WIDTH - 1);
          cnt_d   = '0;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        cnt_d = cnt_q + CW'(1);
        if (differ) begin
          res_d   = res_from_gt(gt);
          used_d  = cnt_q + CW'(1);
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          res_d   = RES_EQ;
          used_d  = cnt_q + CW'(1);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      used_q  <= '0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      used_q  <= used_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.a_gt_b    = res_q[2];
  assign bus.a_lt_b    = res_q[1];
  assign bus.a_eq_b    = res_q[0];
  assign bus.bits_used = used_q;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// Drives six comparator configurations (WIDTH 8/2/16, unsigned and signed)
// from one shared stimulus and checks each against an arithmetic model.
module tb_seq_mag_comparator;
  localparam int NI = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a_drv, b_drv;

  logic [NI-1:0] done_w, busy_w, gt_w, lt_w, eq_w;
  logic [4:0]    used_w [NI];

  int errors = 0;
  int checks = 0;
  int dcyc   [NI];
  int npulse [NI];
  int busy1  [NI];
  logic [2:0] fl_done   [NI];
  logic [4:0] used_done [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g < 2) ? 8 : ((g < 4) ? 2 : 16);
    localparam bit S = ((g % 2) == 1);
    seq_mag_comparator_if #(.WIDTH(W)) bus ();
    assign bus.start  = start;
    assign bus.a      = a_drv[W-1:0];
    assign bus.b      = b_drv[W-1:0];
    assign done_w[g]  = bus.done;
    assign busy_w[g]  = bus.busy;
    assign gt_w[g]    = bus.a_gt_b;
    assign lt_w[g]    = bus.a_lt_b;
    assign eq_w[g]    = bus.a_eq_b;
    assign used_w[g]  = 5'(bus.bits_used);
    seq_mag_comparator #(.WIDTH(W), .SIGNED(S)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  function automatic int cfg_w(input int i);
    return (i < 2) ? 8 : ((i < 4) ? 2 : 16);
  endfunction

  // Reference: numeric compare of (sign-extended) values; bits examined is
  // the distance from the MSB to the highest differing bit, inclusive.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input int w, input bit s,
                                output int k, output logic [2:0] flags);
    logic [31:0] m, am, bm, x;
    longint av, bv;
    int msb;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am = a & m;
    bm = b & m;
    av = longint'(am);
    bv = longint'(bm);
    if (s && am[w-1]) av = av - (longint'(1) << w);
    if (s && bm[w-1]) bv = bv - (longint'(1) << w);
    flags = (av > bv) ? 3'b100 : ((av < bv) ? 3'b010 : 3'b001);
    x   = am ^ bm;
    msb = -1;
    for (int i = 0; i < w; i++) if (x[i]) msb = i;
    k = (msb < 0) ? w : (w - msb);
  endfunction

  // Launch one compare and observe 20 cycles; optional extra start pulse.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         input int pcyc, input logic [31:0] pa, input logic [31:0] pb);
    @(negedge clk);
    a_drv = a;
    b_drv = b;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      dcyc[i] = 0; npulse[i] = 0; busy1[i] = 0;
      fl_done[i] = 3'b000; used_done[i] = 5'd0;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        a_drv = $urandom;
        b_drv = $urandom;
      end
      if (c == pcyc) begin
        start = 1'b1;
        a_drv = pa;
        b_drv = pb;
      end else if (c == pcyc + 1) begin
        start = 1'b0;
      end
      for (int i = 0; i < NI; i++) begin
        if (c == 1) busy1[i] = int'(busy_w[i]);
        if (done_w[i]) begin
          npulse[i]++;
          if (dcyc[i] == 0) begin
            dcyc[i]      = c;
            fl_done[i]   = {gt_w[i], lt_w[i], eq_w[i]};
            used_done[i] = used_w[i];
          end
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_drv = '0; b_drv = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({busy_w[i], done_w[i], gt_w[i], lt_w[i], eq_w[i], used_w[i]} !== 10'd0) begin
        errors++;
        $display("FAIL reset inst%0d: got busy=%b done=%b gt=%b lt=%b eq=%b used=%0d want all 0",
                 i, busy_w[i], done_w[i], gt_w[i], lt_w[i], eq_w[i], used_w[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_equal();
    run_txn(32'hA5, 32'hA5, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dcyc[i] !== 9 || fl_done[i] !== 3'b001 || used_done[i] !== 5'd8) begin
        errors++;
        $display("FAIL equal_a5 inst%0d: got cyc=%0d flags=%b used=%0d want cyc=9 flags=001 used=8",
                 i, dcyc[i], fl_done[i], used_done[i]);
      end
    end
  endtask

  task automatic test_msb_diff();
    run_txn(32'h80, 32'h7F, 0, 0, 0);
    checks++;
    if (dcyc[0] !== 2 || fl_done[0] !== 3'b100 || used_done[0] !== 5'd1) begin
      errors++;
      $display("FAIL msb_unsigned: got cyc=%0d flags=%b used=%0d want cyc=2 flags=100 used=1",
               dcyc[0], fl_done[0], used_done[0]);
    end
    checks++;
    if (dcyc[1] !== 2 || fl_done[1] !== 3'b010 || used_done[1] !== 5'd1) begin
      errors++;
      $display("FAIL msb_signed: got cyc=%0d flags=%b used=%0d want cyc=2 flags=010 used=1",
               dcyc[1], fl_done[1], used_done[1]);
    end
  endtask

  task automatic test_lsb_diff();
    run_txn(32'h12, 32'h13, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dcyc[i] !== 9 || fl_done[i] !== 3'b010 || used_done[i] !== 5'd8) begin
        errors++;
        $display("FAIL lsb_diff inst%0d: got cyc=%0d flags=%b used=%0d want cyc=9 flags=010 used=8",
                 i, dcyc[i], fl_done[i], used_done[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    run_txn(32'd3, 32'd1, 2, 32'd0, 32'd9);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dcyc[i] !== 8 || npulse[i] !== 1 || fl_done[i] !== 3'b100 || used_done[i] !== 5'd7) begin
        errors++;
        $display("FAIL start_in_cmp inst%0d: got cyc=%0d pulses=%0d flags=%b used=%0d want cyc=8 pulses=1 flags=100 used=7",
                 i, dcyc[i], npulse[i], fl_done[i], used_done[i]);
      end
    end
  endtask

  task automatic test_start_in_done();
    run_txn(32'd3, 32'd1, 8, 32'd0, 32'd9);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (npulse[i] !== 1 || busy_w[i] !== 1'b0 || {gt_w[i], lt_w[i], eq_w[i]} !== 3'b100) begin
        errors++;
        $display("FAIL start_in_done inst%0d: got pulses=%0d busy=%b flags=%b want pulses=1 busy=0 flags=100",
                 i, npulse[i], busy_w[i], {gt_w[i], lt_w[i], eq_w[i]});
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    a_drv = 32'hA5; b_drv = 32'hA5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({busy_w[i], done_w[i], gt_w[i], lt_w[i], eq_w[i], used_w[i]} !== 10'd0) begin
        errors++;
        $display("FAIL reset_mid inst%0d: got busy=%b done=%b flags=%b used=%0d want all 0",
                 i, busy_w[i], done_w[i], {gt_w[i], lt_w[i], eq_w[i]}, used_w[i]);
      end
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(done_w[0]) + int'(done_w[1]);
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(done_w[0]) + int'(done_w[1]);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done cycles want 0", seen);
    end
    run_txn(32'hA5, 32'hA5, 0, 0, 0);
    checks++;
    if (dcyc[0] !== 9 || fl_done[0] !== 3'b001 || used_done[0] !== 5'd8) begin
      errors++;
      $display("FAIL after_reset: got cyc=%0d flags=%b used=%0d want cyc=9 flags=001 used=8",
               dcyc[0], fl_done[0], used_done[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    int k;
    logic [2:0] ef;
    for (int n = 0; n < 20; n++) begin
      ra = $urandom;
      rb = $urandom;
      // Bias some pairs to share upper bits so long compares are exercised.
      if (n % 4 == 1) rb = ra;
      if (n % 4 == 2) rb = ra ^ (32'd1 << $urandom_range(0, 3));
      run_txn(ra, rb, 0, 0, 0);
      for (int i = 0; i < NI; i++) begin
        model(ra, rb, cfg_w(i), (i % 2) == 1, k, ef);
        checks++;
        if (fl_done[i] !== ef || used_done[i] !== 5'(k) || dcyc[i] !== k + 1) begin
          errors++;
          $display("FAIL random inst%0d a=%h b=%h: got flags=%b used=%0d cyc=%0d want flags=%b used=%0d cyc=%0d",
                   i, ra, rb, fl_done[i], used_done[i], dcyc[i], ef, k, k + 1);
        end
        checks++;
        if (npulse[i] !== 1 || busy1[i] !== 1) begin
          errors++;
          $display("FAIL random_pulse inst%0d: got pulses=%0d busy_c1=%0d want pulses=1 busy_c1=1",
                   i, npulse[i], busy1[i]);
        end
        checks++;
        if ({gt_w[i], lt_w[i], eq_w[i]} !== ef || used_w[i] !== 5'(k) || busy_w[i] !== 1'b0) begin
          errors++;
          $display("FAIL random_hold inst%0d: got flags=%b used=%0d busy=%b want flags=%b used=%0d busy=0",
                   i, {gt_w[i], lt_w[i], eq_w[i]}, used_w[i], busy_w[i], ef, k);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_msb_diff();
    test_lsb_diff();
    test_ignore_busy();
    test_start_in_done();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_mag_comparator.md
SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be legal for 2..32.
REQ-002 Parameter SIGNED, default 0: 0 compares unsigned operands, 1 compares two's-complement operands.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to compare a and b; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A; captured on an accepted start.
REQ-007 b  input  WIDTH  operand B; captured on an accepted start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking valid results.
REQ-010 a_gt_b, a_lt_b, a_eq_b  output  1 each  registered result flags; exactly one SHALL be high after the first completion.
REQ-011 bits_used  output  $clog2(WIDTH+1)  number of bit positions examined by the last comparison.

Function
REQ-012 FSM states SHALL be IDLE, CMP and DONE.
REQ-013 IDLE with start=1 at an edge: capture a and b, set bit index to WIDTH-1, clear the bit counter, and go to CMP.
REQ-014 IDLE with start=0 SHALL stay in IDLE with all outputs held.
REQ-015 Each CMP cycle SHALL examine one bit, MSB first, and increment the bit counter.
REQ-016 On the first differing bit, the block SHALL set the result and go to DONE (early termination).
REQ-017 In unsigned mode, A bit 1 / B bit 0 SHALL give gt, and A bit 0 / B bit 1 SHALL give lt.
REQ-018 In signed mode, a difference at bit WIDTH-1 SHALL invert that rule; lower bits SHALL follow the unsigned rule.
REQ-019 If bit 0 is reached and equal, the block SHALL set eq and go to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, load bits_used, then return to IDLE.
REQ-021 Latency: start accepted at edge 0, k bits examined, done high in cycle k+1; k=WIDTH for equal operands.
REQ-022 Result flags and bits_used SHALL change only on entry to DONE and SHALL hold until the next DONE.
REQ-023 Changes on a, b or start while busy=1 SHALL be ignored; start asserted during DONE SHALL not be accepted.
REQ-024 The index SHALL never decrement below 0; no wrap-around.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, busy=0, done=0, a_gt_b=0, a_lt_b=0, a_eq_b=0, bits_used=0, and clear captured operands and the index.
REQ-026 Reset mid-comparison SHALL abort it with no done pulse; the first start after rst deasserts SHALL run normally.

Structure
REQ-027 Package seq_cmp_pkg SHALL hold the FSM state encoding and the result-flag encoding constants.
REQ-028 One combinational sub-module, cmp_bit_slice, SHALL take a bit pair plus an is_msb and signed flag, and output differ/gt.
REQ-029 WIDTH and SIGNED SHALL propagate from the top level; no other hard-coded widths are permitted.

Verification (WIDTH=8 unless stated)
REQ-030 a=8'hA5, b=8'hA5, start -> done in cycle 9, a_eq_b=1, bits_used=8.
REQ-031 a=8'h80, b=8'h7F: SIGNED=0 -> done in cycle 2, a_gt_b=1, bits_used=1; SIGNED=1 -> a_lt_b=1.
REQ-032 a=8'h12, b=8'h13 -> done in cycle 9, a_lt_b=1, bits_used=8.
REQ-033 Start a=3,b=1, then pulse start with a=0,b=9 during CMP -> only the first comparison completes, with a_gt_b=1.
REQ-034 rst asserted in cycle 3 of an equal-operand compare -> all outputs 0 at once, no done pulse; the next compare is correct.
REQ-035 20 random pairs for WIDTH=2, 8 and 16, both modes -> flags match a behavioural model; latency=bits_used+1; exactly one flag high.
